fetch_unit: RTL

Instruction fetch stage, directly upstream of `memi`. Holds the PC and drives the `memi` read address. Captures the combinational instruction word into a small FIFO fetch queue and presents it to decode over a valid/ready handshake. A redirect (branch/squash) from the back end flushes the queue and reloads the PC.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode from memi.
// Holds the PC, drives the memi read address, and buffers fetched words in a
// small circular queue presented to decode over a valid/ready handshake.
// A redirect from the back end flushes the queue and reloads the PC.
// Optional feature macro: FETCH_BYPASS_EN - when defined, an empty queue lets
// the word currently returned by memi go straight to decode in the same cycle.

`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif

module fetch_unit #(
  parameter int ADDR_W = `MEMI_SIZE_LOG,
  parameter int INST_W = `INST_LEN,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] memi_req_addr,
  input  logic [INST_W-1:0] memi_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] qPc_q   [QDEPTH];
  logic [INST_W-1:0] qInst_q [QDEPTH];

  logic queueEmpty;
  logic queueFull;
  logic bypassAvail;
  logic bypassTaken;
  logic outValid;
  logic enq;
  logic deq;

  assign queueEmpty = (count_q == '0);
  assign queueFull  = (count_q >= DEPTH_C);

`ifdef FETCH_BYPASS_EN
  assign bypassAvail = queueEmpty;
`else
  assign bypassAvail = 1'b0;
`endif

  // Handshake and queue control: redirect and reset suppress any transfer,
  // and the full test deliberately ignores a same-cycle dequeue.
  always_comb begin
    outValid    = !rst && !redirect_valid && (!queueEmpty || bypassAvail);
    bypassTaken = outValid && out_ready && bypassAvail;
    deq         = outValid && out_ready && !queueEmpty;
    enq         = !rst && !redirect_valid && !queueFull && !bypassTaken;
  end

  // Output path: queue head normally, live memi word when bypassing an empty
  // queue; everything held at zero while reset is asserted.
  always_comb begin
    out_valid     = outValid;
    out_inst      = qInst_q[head_q];
    out_pc        = qPc_q[head_q];
    memi_req_addr = pc_q;
`ifdef FETCH_BYPASS_EN
    if (queueEmpty) begin
      out_inst = memi_resp_data;
      out_pc   = pc_q;
    end
`endif
    if (rst) begin
      out_inst      = '0;
      out_pc        = '0;
      memi_req_addr = '0;
    end
  end

  // Next-state for PC and queue pointers; a redirect wins over everything
  // except reset, which is applied in the register process.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq || bypassTaken) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      if (enq) begin
        tail_d = tail_q + PW'(1);
      end
      if (deq) begin
        head_d = head_q + PW'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CW'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage: capture {pc, memi word} at the tail on enqueue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        qPc_q[i]   <= '0;
        qInst_q[i] <= '0;
      end
    end else if (enq) begin
      qPc_q[tail_q]   <= pc_q;
      qInst_q[tail_q] <= memi_resp_data;
    end
  end

endmodule
